// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter: shares one AXI-Lite manager command port among NREQ
// requesters using round-robin arbitration with one transaction in flight.
// Each grant issues AW+W (or AR) for two cycles, waits for B (or R), then
// holds the response until the consumer accepts it.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog on the wait
// states. It completes with resp_err=2'b11 after TIMEOUT_CYC cycles.
module axi_lite_cmd_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic [1:0]               resp_err,
  output logic [4:0]               tx_en,
  output logic [ADDR_W-1:0]        mgr_tx_AW,
  output logic [DATA_W-1:0]        mgr_tx_W,
  output logic [ADDR_W-1:0]        mgr_tx_AR,
  input  logic [4:0]               mgr_new_data,
  input  logic [DATA_W-1:0]        mgr_rx_R,
  input  logic [1:0]               mgr_rx_RRESP,
  input  logic [1:0]               mgr_rx_BRESP
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam logic [4:0]  TX_WR = 5'b11000;
  localparam logic [4:0]  TX_RD = 5'b00010;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE_W, S_ISSUE_R, S_WAIT_B, S_WAIT_R, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      gnt_q, gnt_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic                iss_q, iss_d;
  logic                armed_q, armed_d;
  logic [NREQ-1:0]     req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [IDW-1:0]      resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]          resp_err_q, resp_err_d;
  logic [4:0]          tx_en_q, tx_en_d;
  logic [ADDR_W-1:0]   aw_q, aw_d;
  logic [DATA_W-1:0]   w_q, w_d;
  logic [ADDR_W-1:0]   ar_q, ar_d;

  logic [IDW-1:0]      pick_c;
  logic                any_c;
  logic                nd_bit_c;
  logic [IDW-1:0]      idx_c;

  logic [ADDR_W-1:0]   addr_a  [NREQ];
  logic [DATA_W-1:0]   wdata_a [NREQ];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0]      wd_q, wd_d;
`else
  logic [31:0]         unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
`endif

  logic unused_nd;
  assign unused_nd = ^{mgr_new_data[4:3], mgr_new_data[1]};

  // Unpack the flat requester buses into per-requester views
  for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_unpack
    assign addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_a[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid requester at or after rr_q, wrapping
  always_comb begin
    pick_c = '0;
    any_c  = 1'b0;
    idx_c  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx_c = IDW'((int'(rr_q) + i) % int'(NREQ));
      if (!any_c && req_valid[idx_c]) begin
        pick_c = idx_c;
        any_c  = 1'b1;
      end
    end
  end

  // Completion bit watched in the current wait state
  assign nd_bit_c = (state_q == S_WAIT_B) ? mgr_new_data[2] : mgr_new_data[0];

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    iss_d        = iss_q;
    armed_d      = armed_q;
    req_ready_d  = '0;
    tx_en_d      = '0;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    aw_d         = aw_q;
    w_d          = w_q;
    ar_d         = ar_q;
`ifdef ARB_TIMEOUT_EN
    wd_d         = wd_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (any_c) begin
          gnt_d               = pick_c;
          req_ready_d[pick_c] = 1'b1;
          state_d             = S_GRANT;
        end
      end

      S_GRANT: begin
        rr_d  = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
        iss_d = 1'b0;
        if (req_we[gnt_q]) begin
          aw_d    = addr_a[gnt_q];
          w_d     = wdata_a[gnt_q];
          tx_en_d = TX_WR;
          state_d = S_ISSUE_W;
        end else begin
          ar_d    = addr_a[gnt_q];
          tx_en_d = TX_RD;
          state_d = S_ISSUE_R;
        end
      end

      S_ISSUE_W, S_ISSUE_R: begin
        if (!iss_q) begin
          iss_d   = 1'b1;
          tx_en_d = (state_q == S_ISSUE_W) ? TX_WR : TX_RD;
        end else begin
          state_d = (state_q == S_ISSUE_W) ? S_WAIT_B : S_WAIT_R;
          armed_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      S_WAIT_B, S_WAIT_R: begin
        // A level already high on entry must drop before it can complete
        if (!nd_bit_c) armed_d = 1'b1;
        if (armed_q && nd_bit_c) begin
          resp_valid_d = 1'b1;
          resp_id_d    = gnt_q;
          resp_rdata_d = (state_q == S_WAIT_B) ? '0 : mgr_rx_R;
          resp_err_d   = (state_q == S_WAIT_B) ? mgr_rx_BRESP : mgr_rx_RRESP;
          state_d      = S_RESP;
`ifdef ARB_TIMEOUT_EN
          wd_d         = '0;
        end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
          resp_valid_d = 1'b1;
          resp_id_d    = gnt_q;
          resp_rdata_d = '0;
          resp_err_d   = 2'b11;
          state_d      = S_RESP;
          wd_d         = '0;
        end else begin
          wd_d         = wd_q + WDW'(1);
`endif
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      rr_q         <= '0;
      iss_q        <= 1'b0;
      armed_q      <= 1'b0;
      req_ready_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
      tx_en_q      <= '0;
      aw_q         <= '0;
      w_q          <= '0;
      ar_q         <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      iss_q        <= iss_d;
      armed_q      <= armed_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      tx_en_q      <= tx_en_d;
      aw_q         <= aw_d;
      w_q          <= w_d;
      ar_q         <= ar_d;
`ifdef ARB_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign tx_en      = tx_en_q;
  assign mgr_tx_AW  = aw_q;
  assign mgr_tx_W   = w_q;
  assign mgr_tx_AR  = ar_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// tb_axi_lite_cmd_arbiter: randomized bench for axi_lite_cmd_arbiter.
// The model works at the transaction level. It tracks the round-robin
// pointer and the pending request set, and predicts each grant, the issued
// command and the returned response.
module tb_axi_lite_cmd_arbiter;

  localparam int unsigned NREQ        = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned IDW         = $clog2(NREQ);

  logic                    ACLK = 1'b0;
  logic                    ARESET;
  logic [NREQ-1:0]         req_valid, req_we;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0]  req_wdata;
  logic [NREQ-1:0]         req_ready;
  logic                    resp_valid, resp_ready;
  logic [IDW-1:0]          resp_id;
  logic [DATA_W-1:0]       resp_rdata;
  logic [1:0]              resp_err;
  logic [4:0]              tx_en;
  logic [ADDR_W-1:0]       mgr_tx_AW, mgr_tx_AR;
  logic [DATA_W-1:0]       mgr_tx_W;
  logic [4:0]              mgr_new_data;
  logic [DATA_W-1:0]       mgr_rx_R;
  logic [1:0]              mgr_rx_RRESP, mgr_rx_BRESP;

  // Requester-side command state
  logic [ADDR_W-1:0]       addr  [NREQ];
  logic [DATA_W-1:0]       wdata [NREQ];

  int n_cmp = 0;
  int n_err = 0;
  int model_rr = 0;

  axi_lite_cmd_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tx_en(tx_en), .mgr_tx_AW(mgr_tx_AW), .mgr_tx_W(mgr_tx_W), .mgr_tx_AR(mgr_tx_AR),
    .mgr_new_data(mgr_new_data), .mgr_rx_R(mgr_rx_R),
    .mgr_rx_RRESP(mgr_rx_RRESP), .mgr_rx_BRESP(mgr_rx_BRESP)
  );

  always #5 ACLK = ~ACLK;

  // Pack requester commands onto the flat buses
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = addr[i];
      req_wdata[i*DATA_W +: DATA_W] = wdata[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  // Reference pick: first pending requester at or after the pointer
  function automatic int model_pick();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_valid[(model_rr + i) % int'(NREQ)]) return (model_rr + i) % int'(NREQ);
    end
    return 0;
  endfunction

  task automatic new_cmd(input int i);
    req_valid[i] = 1'b1;
    req_we[i]    = 1'($urandom_range(0, 1));
    addr[i]      = $urandom;
    wdata[i]     = {$urandom, $urandom};
  endtask

  // Run one transaction from an idle arbiter with at least one pending request
  task automatic do_txn(input bit keep, input int stall, input bit stale,
                        input logic [DATA_W-1:0] rd, input logic [1:0] re);
    int g, n, bitn;
    logic ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [4:0] et;
    logic [NREQ-1:0] onehot;
    g = model_pick();
    onehot = '0;
    onehot[g] = 1'b1;
    n = 0;
    while (req_ready == '0 && n < 20) begin tick(); n++; end
    check("grant_latency", 64'(n), 64'd1);
    check("grant_onehot", 64'(req_ready), 64'(onehot));
    ew = req_we[g];
    ea = addr[g];
    ed = wdata[g];
    et = ew ? 5'b11000 : 5'b00010;
    bitn = ew ? 2 : 0;
    model_rr = (g + 1) % int'(NREQ);
    tick();
    check("ready_pulse", 64'(req_ready), 64'd0);
    if (keep) new_cmd(g); else req_valid[g] = 1'b0;
    check("tx_en_c1", 64'(tx_en), 64'(et));
    if (ew) begin
      check("mgr_tx_AW", 64'(mgr_tx_AW), 64'(ea));
      check("mgr_tx_W", mgr_tx_W, ed);
    end else begin
      check("mgr_tx_AR", 64'(mgr_tx_AR), 64'(ea));
    end
    if (stale) mgr_new_data[bitn] = 1'b1;
    tick();
    check("tx_en_c2", 64'(tx_en), 64'(et));
    tick();
    check("tx_en_off", 64'(tx_en), 64'd0);
    if (stale) begin
      repeat (3) begin tick(); check("stale_ignored", 64'(resp_valid), 64'd0); end
      mgr_new_data = '0;
    end
    repeat ($urandom_range(1, 6)) tick();
    check("no_early_resp", 64'(resp_valid), 64'd0);
    mgr_rx_R     = ew ? {$urandom, $urandom} : rd;
    mgr_rx_RRESP = ew ? 2'($urandom) : re;
    mgr_rx_BRESP = ew ? re : 2'($urandom);
    mgr_new_data[bitn] = 1'b1;
    tick();
    check("resp_valid", 64'(resp_valid), 64'd1);
    check("resp_id", 64'(resp_id), 64'(g));
    check("resp_rdata", resp_rdata, ew ? 64'd0 : rd);
    check("resp_err", 64'(resp_err), 64'(re));
    for (int s = 0; s < stall; s++) begin
      mgr_rx_R = {$urandom, $urandom};
      mgr_rx_RRESP = 2'($urandom);
      mgr_rx_BRESP = 2'($urandom);
      tick();
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_rdata", resp_rdata, ew ? 64'd0 : rd);
      check("stall_err", 64'(resp_err), 64'(re));
      check("stall_no_grant", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready   = 1'b0;
    mgr_new_data = '0;
    check("resp_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, j;
    logic [NREQ-1:0] oh;
    ARESET = 1'b1;
    req_valid = '0; req_we = '0; resp_ready = 1'b0;
    mgr_new_data = '0; mgr_rx_R = '0; mgr_rx_RRESP = '0; mgr_rx_BRESP = '0;
    for (int i = 0; i < int'(NREQ); i++) begin addr[i] = '0; wdata[i] = '0; end
    repeat (3) tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_tx_en", 64'(tx_en), 64'd0);
    check("rst_mgr_tx_W", mgr_tx_W, 64'd0);
    ARESET = 1'b0;

    // T1: write from requester 0
    req_valid[0] = 1'b1; req_we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 64'hA5A5A5A511112222;
    do_txn(1'b0, 0, 1'b0, 64'd0, 2'b00);
    // T2: read from requester 1
    req_valid[1] = 1'b1; req_we[1] = 1'b0; addr[1] = 32'h10;
    do_txn(1'b0, 0, 1'b0, 64'hA5A5A5A511112222, 2'b00);
    // T4: response held off for 10 cycles, another requester waiting
    new_cmd(2); req_we[2] = 1'b1;
    new_cmd(0);
    do_txn(1'b0, 10, 1'b0, 64'd0, 2'b10);
    // Stale-level read from requester 0 (still pending)
    req_we[0] = 1'b0;
    do_txn(1'b0, 1, 1'b1, 64'h0123456789ABCDEF, 2'b01);

    // T5: reset during WAIT_R drops the transaction
    req_valid[3] = 1'b1; req_we[3] = 1'b0; addr[3] = 32'h0000_0F00;
    n = 0;
    while (req_ready == '0 && n < 20) begin tick(); n++; end
    check("t5_grant", 64'(req_ready), 64'b1000);
    tick(); req_valid[3] = 1'b0;
    tick(); tick(); tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    check("t5_req_ready", 64'(req_ready), 64'd0);
    check("t5_resp_valid", 64'(resp_valid), 64'd0);
    check("t5_tx_en", 64'(tx_en), 64'd0);
    check("t5_mgr_tx_AR", 64'(mgr_tx_AR), 64'd0);
    check("t5_mgr_tx_AW", 64'(mgr_tx_AW), 64'd0);
    check("t5_resp_rdata", resp_rdata, 64'd0);
    check("t5_resp_err", 64'(resp_err), 64'd0);
    model_rr = 0;
    mgr_new_data[0] = 1'b1;
    repeat (3) begin
      tick();
      check("t5_no_resp", 64'(resp_valid), 64'd0);
      check("t5_no_grant", 64'(req_ready), 64'd0);
    end
    mgr_new_data = '0;

    // T3: all requesters held valid, expected order 0,1,2,3,0
    for (int i = 0; i < int'(NREQ); i++) new_cmd(i);
    for (int k = 0; k < 5; k++) begin
      check("t3_order", 64'(model_pick()), 64'(k % int'(NREQ)));
      do_txn(1'b1, 0, 1'b0, {$urandom, $urandom}, 2'($urandom));
    end

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < int'(NREQ); i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) new_cmd(i);
      if (req_valid == '0) new_cmd(int'($urandom_range(0, NREQ - 1)));
      do_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), {$urandom, $urandom}, 2'($urandom));
    end

`ifdef ARB_TIMEOUT_EN
    // T6: read left unanswered completes with a timeout error
    req_valid = '0;
    j = model_rr;
    req_valid[j] = 1'b1; req_we[j] = 1'b0; addr[j] = $urandom;
    oh = '0; oh[j] = 1'b1;
    n = 0;
    while (req_ready == '0 && n < 20) begin tick(); n++; end
    check("t6_grant", 64'(req_ready), 64'(oh));
    tick(); req_valid[j] = 1'b0;
    tick(); tick();
    for (int c = 1; c < int'(TIMEOUT_CYC); c++) begin
      tick();
      check("t6_wait", 64'(resp_valid), 64'd0);
    end
    tick();
    check("t6_resp_valid", 64'(resp_valid), 64'd1);
    check("t6_resp_err", 64'(resp_err), 64'b11);
    check("t6_resp_rdata", resp_rdata, 64'd0);
    check("t6_resp_id", 64'(resp_id), 64'(j));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t6_resp_drop", 64'(resp_valid), 64'd0);
    model_rr = (j + 1) % int'(NREQ);
`else
    j = 0;
    oh = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
